gcd_wb_bridge: RTL

- Wishbone-slave to valid/ready bridge inside the Caravel user project. It sits directly upstream of the GCD unit and also consumes its output.
- A Wishbone write carries the packed operands {b[31:16], a[15:0]} and is issued as one request message.
- The GCD result is captured in a small response FIFO and returned on a Wishbone read.
- Both Wishbone reads and writes are blocking: ack is withheld until the transfer can complete.

---
 rtl/gcd_wb_pkg.sv | 19 +
 rtl/gcd_resp_fifo.sv | 65 ++++++
 rtl/gcd_wb_bridge.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/gcd_wb_pkg.sv
// Shared types and constants for the GCD Wishbone bridge.
package gcd_wb_pkg;

    // Default operand/result width of the GCD unit.
    localparam int unsigned OPND_W_DEFAULT = 16;

    // Register offsets decoded from wbs_adr_i[3:2].
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;

    // Bridge control states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        RD_WAIT = 2'd2,
        ACK     = 2'd3
    } state_e;

endpackage

// File: rtl/gcd_resp_fifo.sv
// Small synchronous FIFO buffering GCD results until the bus reads them.
module gcd_resp_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;
    logic [CNT_W-1:0] count_d;

    // A full FIFO refuses pushes even if a pop happens in the same cycle.
    assign do_push_c = push & ~full;
    assign do_pop_c  = pop & ~empty;
    assign dout      = mem[rd_ptr];

    // Next occupancy.
    always_comb begin
        count_d = count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end

    // Pointers, occupancy and registered flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_d;
            full  <= (count_d == CNT_W'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/gcd_wb_bridge.sv
// Wishbone slave front-end for the GCD unit: writes issue requests,
// reads return buffered results; both block until they can complete.
module gcd_wb_bridge
    import gcd_wb_pkg::*;
#(
    parameter int unsigned OPND_W     = OPND_W_DEFAULT,
    parameter int unsigned DATA_W     = 2 * OPND_W,
    parameter int unsigned RESP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [DATA_W-1:0] wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [DATA_W-1:0] wbs_dat_o,
    output logic              req_val,
    input  logic              req_rdy,
    output logic [DATA_W-1:0] req_msg,
    input  logic              resp_val,
    output logic              resp_rdy,
    input  logic [OPND_W-1:0] resp_msg
);

    localparam int unsigned CNT_W = $clog2(RESP_DEPTH) + 1;

    state_e            state_q;
    state_e            state_d;
    logic              ack_d;
    logic              req_val_d;
    logic [DATA_W-1:0] req_msg_d;
    logic [DATA_W-1:0] dat_o_d;
    logic [DATA_W-1:0] status_word_c;
    logic              bus_req_c;
    logic [1:0]        offset_c;
    logic              fifo_push_c;
    logic              fifo_pop_c;
    logic              fifo_full;
    logic              fifo_empty;
    logic [OPND_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              unused_ok;

    assign bus_req_c   = wbs_stb_i & wbs_cyc_i;
    assign offset_c    = wbs_adr_i[3:2];
    assign resp_rdy    = ~fifo_full;
    assign fifo_push_c = resp_val & ~fifo_full;
    assign unused_ok   = &{1'b0, wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

    // STATUS word: occupancy in [15:8], outstanding request in bit 0.
    assign status_word_c = DATA_W'({8'(fifo_count), 7'd0, (state_q == WR_WAIT)});

    // Result buffer between the GCD unit and the bus.
    gcd_resp_fifo #(
        .WIDTH (OPND_W),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push_c),
        .pop   (fifo_pop_c),
        .din   (resp_msg),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_d    = state_q;
        req_msg_d  = req_msg;
        dat_o_d    = wbs_dat_o;
        fifo_pop_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus_req_c) begin
                    if (offset_c == ADDR_DATA) begin
                        if (wbs_we_i) begin
                            req_msg_d = wbs_dat_i;
                            state_d   = WR_WAIT;
                        end else begin
                            state_d = RD_WAIT;
                        end
                    end else begin
                        if (!wbs_we_i) begin
                            dat_o_d = (offset_c == ADDR_STATUS) ? status_word_c : '0;
                        end
                        state_d = ACK;
                    end
                end
            end
            WR_WAIT: begin
                // A dropped cycle abandons the transfer without an ack.
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (req_rdy) begin
                    state_d = ACK;
                end
            end
            RD_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (!fifo_empty) begin
                    fifo_pop_c = 1'b1;
                    dat_o_d    = DATA_W'(fifo_head);
                    state_d    = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ack_d     = (state_d == ACK);
        req_val_d = (state_d == WR_WAIT);
    end

    // State and registered bus/request outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            wbs_ack_o <= 1'b0;
            req_val   <= 1'b0;
            req_msg   <= '0;
            wbs_dat_o <= '0;
        end else begin
            state_q   <= state_d;
            wbs_ack_o <= ack_d;
            req_val   <= req_val_d;
            req_msg   <= req_msg_d;
            wbs_dat_o <= dat_o_d;
        end
    end

endmodule
